// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, fixed-latency memory between instruction fetch
//   (IF) and the data stage (MEM). Accesses are serialised through an
//   IDLE -> ISSUE -> WAIT -> DONE sequence. Read data is captured into a
//   per-side register and announced with a one-cycle ready pulse.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   if_req/if_addr        fetch request and address
//   if_rdata/if_ready     fetched word (registered) and completion pulse
//   d_read/d_write        data-stage read/write (both high = write)
//   d_addr/d_wdata        data address and store data
//   d_rdata/d_ready       load data (registered) and completion pulse
//   ram_en/ram_we         memory strobe and write enable
//   ram_addr/ram_wdata    memory address and write data
//   ram_rdata             memory read data, MEM_LATENCY cycles after ram_en
//   stall                 pipeline freeze while any requester waits
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              stall
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
    $error("mem_port_arbiter: MEM_LATENCY must be in 1..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  // grant / last_grant encoding: 1 = data side, 0 = fetch side
  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic d_req;
  logic pick_d;

  assign d_req = d_read | d_write;

  // Contention goes to the side that did not win last time.
  assign pick_d = d_req & (~if_req | ~last_grant_q);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (d_req | if_req) begin
          // Latch the winner's request so later input changes cannot
          // disturb the access in flight.
          state_d = S_ISSUE;
          grant_d = pick_d;
          if (pick_d) begin
            addr_d  = d_addr;
            wdata_d = d_wdata;
            we_d    = d_write;
          end else begin
            addr_d  = if_addr;
            we_d    = 1'b0;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (grant_q && !we_q) d_rdata_d  = ram_rdata;
          if (!grant_q)         if_rdata_d = ram_rdata;
          last_grant_d = grant_q;
          state_d      = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; everything except stall comes from registered state.
  always_comb begin
    ram_en    = (state_q == S_ISSUE);
    ram_we    = (state_q == S_ISSUE) & we_q;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    if_ready  = (state_q == S_DONE) & ~grant_q;
    d_ready   = (state_q == S_DONE) & grant_q;
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
    stall     = (d_req & ~d_ready) | (if_req & ~if_ready);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  typedef struct {
    bit          is_d;
    bit          chk;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk, reset;
  int   cyc = 0;
  int   errors = 0, checks = 0;

  // DUT A: MEM_LATENCY = 2
  logic        if_req_a, d_read_a, d_write_a;
  logic [31:0] if_addr_a, d_addr_a, d_wdata_a;
  logic [31:0] if_rdata_a, d_rdata_a, ram_addr_a, ram_wdata_a, ram_rdata_a;
  logic        if_ready_a, d_ready_a, ram_en_a, ram_we_a, stall_a;
  // DUT B: MEM_LATENCY = 1
  logic        if_req_b, d_read_b, d_write_b;
  logic [31:0] if_addr_b, d_addr_b, d_wdata_b;
  logic [31:0] if_rdata_b, d_rdata_b, ram_addr_b, ram_wdata_b, ram_rdata_b;
  logic        if_ready_b, d_ready_b, ram_en_b, ram_we_b, stall_b;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2)) u_a (
    .clk(clk), .reset(reset),
    .if_req(if_req_a), .if_addr(if_addr_a), .if_rdata(if_rdata_a), .if_ready(if_ready_a),
    .d_read(d_read_a), .d_write(d_write_a), .d_addr(d_addr_a), .d_wdata(d_wdata_a),
    .d_rdata(d_rdata_a), .d_ready(d_ready_a),
    .ram_en(ram_en_a), .ram_we(ram_we_a), .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a),
    .ram_rdata(ram_rdata_a), .stall(stall_a)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) u_b (
    .clk(clk), .reset(reset),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_rdata(if_rdata_b), .if_ready(if_ready_b),
    .d_read(d_read_b), .d_write(d_write_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
    .d_rdata(d_rdata_b), .d_ready(d_ready_b),
    .ram_en(ram_en_b), .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b),
    .ram_rdata(ram_rdata_b), .stall(stall_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory models; idle cycles return a poison word so mistimed captures show.
  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];
  logic [31:0] pa0, pa1, pb0;
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;
  int          en_cnt_a = 0;

  always @(posedge clk) begin
    if (pl_en) begin
      mem_a[pl_addr] <= pl_data;
      mem_b[pl_addr] <= pl_data;
    end
    if (ram_en_a && ram_we_a) mem_a[ram_addr_a[9:2]] <= ram_wdata_a;
    if (ram_en_b && ram_we_b) mem_b[ram_addr_b[9:2]] <= ram_wdata_b;
    pa0 <= ram_en_a ? mem_a[ram_addr_a[9:2]] : 32'hBAD0BAD0;
    pa1 <= pa0;
    pb0 <= ram_en_b ? mem_b[ram_addr_b[9:2]] : 32'hBAD0BAD0;
    if (ram_en_a) en_cnt_a <= en_cnt_a + 1;
  end
  assign ram_rdata_a = pa1;
  assign ram_rdata_b = pb0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_a(input bit is_d, input bit chk, input logic [31:0] d, input int cy);
    exp_t e;
    e.is_d = is_d; e.chk = chk; e.data = d; e.cyc = cy;
    qa.push_back(e);
  endtask

  task automatic push_b(input bit is_d, input bit chk, input logic [31:0] d, input int cy);
    exp_t e;
    e.is_d = is_d; e.chk = chk; e.data = d; e.cyc = cy;
    qb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: every ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (if_ready_a || d_ready_a) begin
      if (if_ready_a && d_ready_a) check("A both ready", 1, 0);
      if (qa.size() == 0) begin
        check("A unexpected ready", {if_ready_a, d_ready_a}, 0);
      end else begin
        ea = qa.pop_front();
        check("A ready side", d_ready_a, ea.is_d);
        check("A ready cycle", cyc, ea.cyc);
        if (ea.chk) check("A rdata", ea.is_d ? d_rdata_a : if_rdata_a, ea.data);
      end
    end
  end

  always @(negedge clk) begin
    if (if_ready_b || d_ready_b) begin
      if (qb.size() == 0) begin
        check("B unexpected ready", {if_ready_b, d_ready_b}, 0);
      end else begin
        eb = qb.pop_front();
        check("B ready side", d_ready_b, eb.is_d);
        check("B ready cycle", cyc, eb.cyc);
        if (eb.chk) check("B rdata", eb.is_d ? d_rdata_b : if_rdata_b, eb.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, r, en0;
    reset = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    if_req_a = 0; d_read_a = 0; d_write_a = 0; if_addr_a = 0; d_addr_a = 0; d_wdata_a = 0;
    if_req_b = 0; d_read_b = 0; d_write_b = 0; if_addr_b = 0; d_addr_b = 0; d_wdata_b = 0;
    step; pl_en = 1; pl_addr = 8'h10; pl_data = 32'h20080005;   // word 0x40
    step; pl_addr = 8'h20; pl_data = 32'hCAFEF00D;              // word 0x80
    step; pl_en = 0;
    @(negedge clk);
    check("rst if_ready", if_ready_a, 0);
    check("rst d_ready", d_ready_a, 0);
    check("rst ram_en", ram_en_a, 0);
    check("rst ram_we", ram_we_a, 0);
    check("rst ram_addr", ram_addr_a, 0);
    check("rst ram_wdata", ram_wdata_a, 0);
    check("rst if_rdata", if_rdata_a, 0);
    check("rst d_rdata", d_rdata_a, 0);
    check("rst stall", stall_a, 0);
    step; reset = 0;
    step;

    // Single fetch, latency 2
    step; c = cyc; if_req_a = 1; if_addr_a = 32'h40;
    push_a(0, 1, 32'h20080005, c + 4);
    @(negedge clk); check("t1 stall c0", stall_a, 1); check("t1 en c0", ram_en_a, 0);
    step; @(negedge clk);
    check("t1 en c1", ram_en_a, 1); check("t1 we c1", ram_we_a, 0);
    check("t1 addr c1", ram_addr_a, 32'h40); check("t1 stall c1", stall_a, 1);
    step; @(negedge clk); check("t1 stall c2", stall_a, 1); check("t1 en c2", ram_en_a, 0);
    step; @(negedge clk); check("t1 stall c3", stall_a, 1);
    step; @(negedge clk); check("t1 stall c4", stall_a, 0);
    step; if_req_a = 0;
    @(negedge clk); check("t1 ram_addr hold", ram_addr_a, 32'h40);

    // Store then load the same word
    step; c = cyc; en0 = en_cnt_a;
    d_write_a = 1; d_addr_a = 32'h100; d_wdata_a = 32'hDEADBEEF;
    push_a(1, 0, 32'h0, c + 4);
    step; @(negedge clk);
    check("t2 en", ram_en_a, 1); check("t2 we", ram_we_a, 1);
    check("t2 addr", ram_addr_a, 32'h100); check("t2 wdata", ram_wdata_a, 32'hDEADBEEF);
    repeat (4) step;
    d_write_a = 0; d_read_a = 1;
    push_a(1, 1, 32'hDEADBEEF, c + 9);
    step; @(negedge clk); check("t2 rd en", ram_en_a, 1); check("t2 rd we", ram_we_a, 0);
    repeat (4) step;
    d_read_a = 0;
    step; step;
    check("t2 en count", en_cnt_a - en0, 2);

    // Contention held from reset: D, I, D, I
    reset = 1; if_req_a = 1; if_addr_a = 32'h40; d_read_a = 1; d_addr_a = 32'h100;
    step; step; reset = 0; r = cyc; en0 = en_cnt_a;
    push_a(1, 1, 32'hDEADBEEF, r + 4);
    push_a(0, 1, 32'h20080005, r + 9);
    push_a(1, 1, 32'hDEADBEEF, r + 14);
    push_a(0, 1, 32'h20080005, r + 19);
    repeat (20) step;
    if_req_a = 0; d_read_a = 0;
    step; step;
    check("t4 en count", en_cnt_a - en0, 4);

    // Read and write both high -> write wins
    step; c = cyc; d_read_a = 1; d_write_a = 1; d_addr_a = 32'h10; d_wdata_a = 32'h1234;
    push_a(1, 0, 32'h0, c + 4);
    step; @(negedge clk);
    check("t3 we", ram_we_a, 1); check("t3 wdata", ram_wdata_a, 32'h1234);
    check("t3 addr", ram_addr_a, 32'h10);
    repeat (4) step;
    d_write_a = 0;
    push_a(1, 1, 32'h1234, c + 9);
    step; @(negedge clk); check("t3 rd we", ram_we_a, 0);
    repeat (4) step;
    d_read_a = 0;
    step;

    // Reset during WAIT of a fetch
    step; c = cyc; if_req_a = 1; if_addr_a = 32'h40;
    step; @(negedge clk); check("t5 en", ram_en_a, 1);
    step; reset = 1; if_req_a = 0;
    step; reset = 0;
    @(negedge clk);
    check("t5 en after rst", ram_en_a, 0); check("t5 if_ready", if_ready_a, 0);
    check("t5 if_rdata rst", if_rdata_a, 0); check("t5 stall", stall_a, 0);
    step; if_req_a = 1;
    push_a(0, 1, 32'h20080005, c + 8);
    @(negedge clk); check("t5 no stale ready", if_ready_a, 0);
    repeat (5) step;
    if_req_a = 0;
    step;

    // Latency-1 fetch: WAIT lasts one cycle, ready 3 cycles after request
    step; c = cyc; if_req_b = 1; if_addr_b = 32'h80;
    push_b(0, 1, 32'hCAFEF00D, c + 3);
    @(negedge clk); check("t6 en c0", ram_en_b, 0);
    step; @(negedge clk); check("t6 en c1", ram_en_b, 1);
    step; @(negedge clk); check("t6 en c2", ram_en_b, 0); check("t6 stall c2", stall_b, 1);
    step; @(negedge clk); check("t6 stall c3", stall_b, 0);
    step; if_req_b = 0;

    for (int i = 0; i < 50 && (qa.size() != 0 || qb.size() != 0); i++) step;
    check("A queue drained", qa.size(), 0);
    check("B queue drained", qb.size(), 0);
    step;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the IF stage (instruction fetch) and the MEM stage (lw/sw driven by MemRead/MemWrite from the Control decode).
- Serialises accesses through a small FSM and returns registered read data with a one-cycle ready pulse per requester.
- Produces a pipeline stall that holds the pipeline while any stage waits on memory.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits.
- MEM_LATENCY, 2, cycles from the ram_en cycle until ram_rdata is valid; legal range is 1 to 15.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  IF stage requests an instruction read.
- if_addr  in  ADDR_W  fetch address (PC).
- if_rdata  out  DATA_W  fetched instruction; registered.
- if_ready  out  1  one-cycle pulse: if_rdata is valid.
- d_read  in  1  MEM-stage MemRead.
- d_write  in  1  MEM-stage MemWrite.
- d_addr  in  ADDR_W  data address (ALU result).
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; registered.
- d_ready  out  1  one-cycle pulse: data access complete.
- ram_en  out  1  memory access strobe.
- ram_we  out  1  write enable; qualified by ram_en.
- ram_addr  out  ADDR_W  memory address.
- ram_wdata  out  DATA_W  memory write data.
- ram_rdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after ram_en.
- stall  out  1  pipeline freeze.

Behaviour:
- d_req = d_read | d_write. If d_read and d_write are both high, the access is a write.
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are decoded from registered state, grant and latched request fields. The only exception is stall, which is combinational.
- IDLE transitions:
  - Only d_req pending: grant D, go to ISSUE.
  - Only if_req pending: grant I, go to ISSUE.
  - Both pending: grant the side opposite to last_grant, go to ISSUE.
  - Neither pending: stay in IDLE.
- On leaving IDLE, latch the granted side's address, wdata and write flag. Later changes on request inputs do not affect an access in flight.
- ISSUE lasts 1 cycle:
  - ram_en=1; ram_addr and ram_wdata come from the latched values.
  - ram_we=1 only for a D write.
  - Load cnt = MEM_LATENCY-1, go to WAIT.
- WAIT:
  - cnt != 0: decrement cnt.
  - cnt == 0: capture ram_rdata into d_rdata or if_rdata (granted side only; writes capture nothing), update last_grant, go to DONE.
- DONE lasts 1 cycle: pulse if_ready or d_ready for the granted side, then go to IDLE.
- Latency: request first seen in an IDLE cycle → ready pulse MEM_LATENCY+2 cycles later. Minimum spacing between ram_en pulses is MEM_LATENCY+3 cycles.
- A requester dropping its request mid-access does not abort the access; the access completes and ready still pulses.
- stall = (d_req & ~d_ready) | (if_req & ~if_ready).
- Outside ISSUE: ram_en=0, ram_we=0. ram_addr and ram_wdata hold their last values.
- if_rdata and d_rdata hold their values until the next capture for the same side.
- Reset values: state=IDLE, last_grant=I (so data wins the first contention), cnt=0, if_ready=0, d_ready=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, if_rdata=0, d_rdata=0.
- Reset asserted mid-access (ISSUE or WAIT or DONE):
  - Next cycle the FSM is in IDLE with all outputs at reset values.
  - No ready pulse is issued for the aborted access.
  - Late ram_rdata is ignored.

Test Plan:
- MEM_LATENCY=2, memory preloaded with 0x20080005 at 0x40; if_req=1, if_addr=0x40 raised in cycle 0 → ram_en in cycle 1, if_ready pulse in cycle 4 with if_rdata=0x20080005; stall=1 in cycles 0-3 and 0 in cycle 4.
- d_write=1, d_addr=0x100, d_wdata=0xDEADBEEF, then d_read=1 at 0x100 → single ram_en with ram_we=1 on the write; read then returns d_rdata=0xDEADBEEF with one d_ready pulse per access.
- if_req and d_read held high together from reset → grant order D, I, D, I; each pulse spaced MEM_LATENCY+3 cycles; neither side starves.
- MEM_LATENCY=1 boundary: single fetch → ready 3 cycles after request; WAIT lasts exactly 1 cycle.
- d_read=1 and d_write=1 both high, addr 0x10, wdata 0x1234 → ram_we=1; a subsequent read of 0x10 returns 0x1234.
- reset pulsed during WAIT of a fetch → no if_ready; ram_en=0; the next request restarts from IDLE with correct data.
